intdivseq: RTL and testbench
============================

INTDIVSEQ -- requirements
Module: intdivseq

Interface
REQ-001 SHALL have parameter: XLEN, 32, integer datapath width; legal values 32 and 64.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: StallM  input  1  Memory stage stalled; holds DONE state.
REQ-005 SHALL have port: FlushE  input  1  abort the Execute-stage division.
REQ-006 SHALL have port: IntDivE  input  1  Execute-stage instruction is DIV/DIVU/REM/REMU.
REQ-007 SHALL have port: ForwardedSrcAE  input  XLEN  dividend after forwarding.
REQ-008 SHALL have port: ForwardedSrcBE  input  XLEN  divisor after forwarding.
REQ-009 SHALL have port: Funct3E  input  3  operation select: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-010 SHALL have port: DivBusyE  output  1  division in progress; stalls the pipeline.
REQ-011 SHALL have port: DivResultE  output  XLEN  final quotient or remainder.

Function
REQ-012 SHALL implement states IDLE, BUSY and DONE, with a log2(XLEN)-bit iteration counter.
REQ-013 SHALL transition IDLE->BUSY when IntDivE & ~FlushE; on that edge it captures operand magnitudes, signedness (Funct3E[0]==0), the select (Funct3E[1]) and the divide-by-zero and overflow flags, and loads counter=XLEN-1.
REQ-014 SHALL in BUSY perform one restoring shift-subtract step per cycle on unsigned magnitudes, producing one quotient bit MSB-first and decrementing the counter.
REQ-015 SHALL transition BUSY->DONE on the cycle the counter equals 0 (XLEN BUSY cycles).
REQ-016 SHALL remain in DONE while StallM and transition DONE->IDLE when ~StallM; IntDivE SHALL be ignored in DONE.
REQ-017 SHALL drive DivBusyE = (IDLE & IntDivE & ~FlushE) | BUSY; it is low in DONE.
REQ-018 SHALL have latency: start accepted in cycle N, BUSY in N+1..N+XLEN, DONE with valid DivResultE in N+XLEN+1, and DivBusyE high in N..N+XLEN; latency SHALL be fixed for all operands.
REQ-019 SHALL negate the quotient iff signed and the operand signs differ, and negate the remainder iff signed and the dividend is negative.
REQ-020 SHALL for divisor==0 produce quotient all-ones and remainder equal to the original dividend, for both signed and unsigned operations.
REQ-021 SHALL for signed overflow (dividend=most-negative, divisor=-1) produce quotient equal to the dividend and remainder 0.
REQ-022 SHALL latch DivResultE when entering DONE and hold it until the next accepted start.
REQ-023 SHALL on FlushE in BUSY or DONE return to IDLE on the next edge, drop DivBusyE from the next cycle, and leave DivResultE unchanged.
REQ-024 SHALL give FlushE priority over StallM in all states.
REQ-025 SHALL operate on full XLEN only; W-form operations are out of scope for this block.

Reset
REQ-026 SHALL on reset, in any state including mid-BUSY, enter IDLE on the next edge with counter=0, DivBusyE=0 and DivResultE=0.
REQ-027 SHALL give reset priority over FlushE, IntDivE and StallM.

Verification (XLEN=32)
REQ-028 SHALL cover: DIV A=0xFFFFFFF9 (-7), B=2 -> DivResultE=0xFFFFFFFD at N+33, DivBusyE high exactly in N..N+32; REM with the same operands -> 0xFFFFFFFF.
REQ-029 SHALL cover: DIVU A=0x12345678, B=0 -> 0xFFFFFFFF; REMU with the same operands -> 0x12345678; REM A=0xFFFFFFF9, B=0 -> 0xFFFFFFF9.
REQ-030 SHALL cover: DIV A=0x80000000, B=0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0x00000000.
REQ-031 SHALL cover: FlushE pulsed in BUSY cycle N+10 -> IDLE at N+11, DivBusyE=0 from N+11, DivResultE retains its prior value.
REQ-032 SHALL cover: DONE with StallM held 3 cycles -> state and result held, DivBusyE=0; back-to-back DIVU 100/7 then REMU 100/7 -> 14 then 2, each with full latency.
REQ-033 SHALL cover: reset asserted in BUSY cycle N+5 -> IDLE, DivBusyE=0 and DivResultE=0 after the edge; a subsequent DIVU 9/3 -> 3.

Source files
------------

// File: rtl/intdivseq.sv
// Sequential integer divider for the Execute stage.
// Handles DIV/DIVU/REM/REMU at full XLEN width. It runs a restoring
// shift-subtract on operand magnitudes, one quotient bit per cycle, so the
// latency is the same for every operand pair. Divide-by-zero and signed
// overflow are flagged at start and produce their fixed results at the end.
module intdivseq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallM,
    input  logic            FlushE,
    input  logic            IntDivE,
    input  logic [XLEN-1:0] ForwardedSrcAE,
    input  logic [XLEN-1:0] ForwardedSrcBE,
    input  logic [2:0]      Funct3E,
    output logic            DivBusyE,
    output logic [XLEN-1:0] DivResultE
);

    localparam int CW = $clog2(XLEN);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Control state
    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;

    // Datapath state (operands, partial remainder, quotient shift register)
    logic [XLEN-1:0] rem_q, quot_q, dvsr_q, dvnd_q;
    logic            sel_q, dz_q, ovf_q, negq_q, negr_q;

    logic            start;
    logic            a_neg, b_neg, is_signed;
    logic [XLEN:0]   rshift, diff;
    logic            qbit;
    logic [XLEN-1:0] rem_step, quot_step, q_final, r_final;
    logic            unused_f3;

    // Two's-complement negate when the sign fix-up applies.
    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v,
                                                 input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    assign unused_f3 = Funct3E[2];

    // Start decode, one restoring step and final sign/corner-case fix-up.
    always_comb begin
        start     = (state_q == IDLE) & IntDivE & ~FlushE;
        DivBusyE  = start | (state_q == BUSY);
        is_signed = ~Funct3E[0];
        a_neg     = is_signed & ForwardedSrcAE[XLEN-1];
        b_neg     = is_signed & ForwardedSrcBE[XLEN-1];

        // Shift the next dividend bit into the partial remainder and try a subtract.
        rshift    = {rem_q, quot_q[XLEN-1]};
        diff      = rshift - {1'b0, dvsr_q};
        qbit      = ~diff[XLEN];
        rem_step  = qbit ? diff[XLEN-1:0] : rshift[XLEN-1:0];
        quot_step = {quot_q[XLEN-2:0], qbit};

        // Divide-by-zero takes precedence; the two cases cannot coexist anyway.
        if (dz_q) begin
            q_final = '1;
            r_final = dvnd_q;
        end else if (ovf_q) begin
            q_final = dvnd_q;
            r_final = '0;
        end else begin
            q_final = cond_neg(quot_step, negq_q);
            r_final = cond_neg(rem_step, negr_q);
        end
    end

    // Next-state logic: reset beats flush, flush beats stall and start.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        if (reset) begin
            state_d  = IDLE;
            cnt_d    = '0;
            result_d = '0;
        end else if (FlushE) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (IntDivE) begin
                        state_d = BUSY;
                        cnt_d   = CW'(XLEN - 1);
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        state_d  = DONE;
                        result_d = sel_q ? r_final : q_final;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    if (!StallM) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Control registers.
    always_ff @(posedge clk) begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        result_q <= result_d;
    end

    // Datapath registers: capture operands on start, iterate while busy.
    always_ff @(posedge clk) begin
        if (start) begin
            rem_q  <= '0;
            quot_q <= a_neg ? (~ForwardedSrcAE + 1'b1) : ForwardedSrcAE;
            dvsr_q <= b_neg ? (~ForwardedSrcBE + 1'b1) : ForwardedSrcBE;
            dvnd_q <= ForwardedSrcAE;
            sel_q  <= Funct3E[1];
            dz_q   <= (ForwardedSrcBE == '0);
            ovf_q  <= is_signed & (ForwardedSrcAE == {1'b1, {(XLEN-1){1'b0}}})
                      & (ForwardedSrcBE == '1);
            negq_q <= a_neg ^ b_neg;
            negr_q <= a_neg;
        end else if (state_q == BUSY) begin
            rem_q  <= rem_step;
            quot_q <= quot_step;
        end
    end

    assign DivResultE = result_q;

endmodule

// File: tb/tb_intdivseq.sv
// Self-checking bench for intdivseq (XLEN=32): directed corner cases plus
// randomized operations compared against a plain-arithmetic reference.
module tb_intdivseq;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset, StallM, FlushE, IntDivE;
    logic [XLEN-1:0] SrcA, SrcB;
    logic [2:0]      Funct3E;
    logic            DivBusyE;
    logic [XLEN-1:0] DivResultE;

    int n_cmp = 0;
    int n_bad = 0;

    intdivseq #(.XLEN(XLEN)) dut (
        .clk           (clk),
        .reset         (reset),
        .StallM        (StallM),
        .FlushE        (FlushE),
        .IntDivE       (IntDivE),
        .ForwardedSrcAE(SrcA),
        .ForwardedSrcBE(SrcB),
        .Funct3E       (Funct3E),
        .DivBusyE      (DivBusyE),
        .DivResultE    (DivResultE)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // RISC-V M-extension semantics from plain arithmetic.
    function automatic logic [31:0] ref_div(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [2:0] f3);
        longint sa, sb;
        if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
        if (!f3[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return f3[1] ? 32'd0 : a;
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return f3[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return f3[1] ? (a % b) : (a / b);
    endfunction

    // Cycle N: present the operation; busy must rise combinationally.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] f3);
        @(negedge clk);
        SrcA = a; SrcB = b; Funct3E = f3; IntDivE = 1'b1;
        #1 check_val("busy_start", DivBusyE, 1'b1);
    endtask

    // Cycles N+1..N+32 busy, N+33 done with the result.
    task automatic finish_op(input logic [31:0] exp);
        for (int i = 1; i <= XLEN; i++) begin
            @(negedge clk);
            IntDivE = 1'($urandom_range(0, 1));
            SrcA = $urandom; SrcB = $urandom;
            #1 check_val("busy_iter", DivBusyE, 1'b1);
        end
        @(negedge clk);
        IntDivE = 1'b0;
        check_val("busy_done", DivBusyE, 1'b0);
        check_val("result", DivResultE, exp);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] f3);
        start_op(a, b, f3);
        finish_op(ref_div(a, b, f3));
    endtask

    logic [31:0] held, ra, rb;
    logic [2:0]  rf;

    initial begin
        reset = 1'b1; StallM = 1'b0; FlushE = 1'b0; IntDivE = 1'b0;
        SrcA = '0; SrcB = '0; Funct3E = 3'b100;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_val("rst_busy", DivBusyE, 1'b0);
        check_val("rst_result", DivResultE, 32'd0);

        // Signed division/remainder of a negative dividend.
        start_op(32'hFFFF_FFF9, 32'd2, 3'b100);
        finish_op(32'hFFFF_FFFD);
        start_op(32'hFFFF_FFF9, 32'd2, 3'b110);
        finish_op(32'hFFFF_FFFF);

        // Divide by zero.
        start_op(32'h1234_5678, 32'd0, 3'b101);
        finish_op(32'hFFFF_FFFF);
        start_op(32'h1234_5678, 32'd0, 3'b111);
        finish_op(32'h1234_5678);
        start_op(32'hFFFF_FFF9, 32'd0, 3'b110);
        finish_op(32'hFFFF_FFF9);
        start_op(32'hFFFF_FFF9, 32'd0, 3'b100);
        finish_op(32'hFFFF_FFFF);

        // Signed overflow.
        start_op(32'h8000_0000, 32'hFFFF_FFFF, 3'b100);
        finish_op(32'h8000_0000);
        start_op(32'h8000_0000, 32'hFFFF_FFFF, 3'b110);
        finish_op(32'h0000_0000);

        // Stall in DONE for 3 cycles; a new request there is ignored.
        start_op(32'd100, 32'd7, 3'b101);
        finish_op(32'd14);
        StallM = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            IntDivE = 1'b1; SrcA = 32'd50; SrcB = 32'd5; Funct3E = 3'b101;
            #1 check_val("stall_busy", DivBusyE, 1'b0);
            check_val("stall_result", DivResultE, 32'd14);
        end
        IntDivE = 1'b0; StallM = 1'b0;
        start_op(32'd100, 32'd7, 3'b111);
        finish_op(32'd2);

        // Back-to-back with no gap.
        run_op(32'd100, 32'd7, 3'b101);
        run_op(32'd100, 32'd7, 3'b111);

        // Flush in BUSY cycle N+10.
        held = DivResultE;
        start_op(32'd1000, 32'd3, 3'b101);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            IntDivE = 1'b0;
        end
        FlushE = 1'b1;
        #1 check_val("flush_busy_pre", DivBusyE, 1'b1);
        @(negedge clk);
        FlushE = 1'b0;
        check_val("flush_busy", DivBusyE, 1'b0);
        check_val("flush_result", DivResultE, held);
        repeat (30) begin
            @(negedge clk);
            check_val("flush_idle", DivBusyE, 1'b0);
        end
        check_val("flush_result_late", DivResultE, held);

        // Flush wins over stall in DONE: next cycle must be IDLE.
        start_op(32'd77, 32'd8, 3'b111);
        finish_op(32'd5);
        StallM = 1'b1; FlushE = 1'b1;
        @(negedge clk);
        StallM = 1'b0; FlushE = 1'b0;
        SrcA = 32'd81; SrcB = 32'd9; Funct3E = 3'b101; IntDivE = 1'b1;
        #1 check_val("flushdone_idle", DivBusyE, 1'b1);
        finish_op(32'd9);

        // Reset in BUSY cycle N+5.
        start_op(32'hDEAD_BEEF, 32'd17, 3'b100);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            IntDivE = 1'b0;
        end
        reset = 1'b1; FlushE = 1'b1; StallM = 1'b1;
        @(negedge clk);
        reset = 1'b0; FlushE = 1'b0; StallM = 1'b0;
        check_val("rst_mid_busy", DivBusyE, 1'b0);
        check_val("rst_mid_result", DivResultE, 32'd0);
        run_op(32'd9, 32'd3, 3'b101);

        // Randomized operations with corner operands and random stalls.
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 5))
                0: ra = 32'h8000_0000;
                1: ra = 32'hFFFF_FFFF;
                2: ra = 32'd0;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'(($urandom_range(1, 15)));
                3: rb = 32'h8000_0000;
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            rf = 3'(4 + $urandom_range(0, 3));
            run_op(ra, rb, rf);
            held = ref_div(ra, rb, rf);
            StallM = 1'($urandom_range(0, 1));
            if (StallM) begin
                @(negedge clk);
                check_val("rand_stall_busy", DivBusyE, 1'b0);
                check_val("rand_stall_result", DivResultE, held);
                StallM = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
